rf_write_arbiter: RTL
=====================

Name: rf_write_arbiter

Overview:
- Owns the single register-file write port. Shares it between the pipeline write-back stage (regWrite/regSel/wdat) and a long-latency auxiliary unit, such as a multiply/divide unit.
- Pipeline writes have priority. Auxiliary results queue in a small FIFO and drain on idle write-port cycles.
- A starvation counter forces a one-cycle pipeline stall when aux results wait too long.
- Keeps a pending-write scoreboard so decode can stall on registers owed by the aux unit.

Parameters:
FIFO_DEPTH, 2, aux result FIFO entries (power of 2, >=2)
STARVE_LIMIT, 4, consecutive non-granted cycles with FIFO non-empty before forcing a stall (>=1)

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
pipe_wen  input  1  WB stage regWrite
pipe_sel  input  5  WB stage destination register
pipe_wdat  input  32  WB stage write data
aux_valid  input  1  aux result valid
aux_sel  input  5  aux destination register
aux_wdat  input  32  aux result data
aux_ready  output  1  FIFO can accept an aux result
issue_en  input  1  aux operation issued this cycle
issue_sel  input  5  destination of issued aux operation
rf_wen  output  1  register-file write enable
rf_wsel  output  5  register-file write select
rf_wdat  output  32  register-file write data
stall_pipe  output  1  freeze pipeline this cycle
pending_mask  output  32  bit r set = aux write to register r outstanding
fifo_count  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy

Behaviour:
- Clock and reset: one clock CLK; reset nRST is asynchronous, active-low.
- Reset values: rf_wen=0, rf_wsel=0, rf_wdat=0, stall_pipe=0, pending_mask=0, fifo_count=0, starve_cnt=0, FIFO pointers 0.
- aux_ready:
  - aux_ready = (fifo_count < FIFO_DEPTH), derived from registered count only.
  - No same-cycle pop-to-push bypass when full.
- FIFO push:
  - A push occurs when aux_valid && aux_ready.
  - If aux_sel==0, the result is accepted (handshake completes) but discarded; nothing is enqueued.
- stall_pipe = (starve_cnt == STARVE_LIMIT).
  - While stall_pipe=1, pipe_wen is ignored. The pipeline holds its WB latch and re-presents the write next cycle.
- Grant priority, evaluated each cycle:
  1. stall_pipe=1: grant aux head.
  2. pipe_wen && pipe_sel!=0: grant pipe.
  3. fifo_count>0: grant aux head.
  4. Otherwise no grant.
- pipe_wen with pipe_sel==0 is treated as no request.
- Write port:
  - Registered, 1-cycle latency. At each edge rf_wen/rf_wsel/rf_wdat load the granted request.
  - With no grant, rf_wen<=0; rf_wsel/rf_wdat hold.
  - An aux grant pops the FIFO head at the same edge.
- FIFO push and pop in the same cycle: count unchanged, order preserved. Pointers wrap modulo FIFO_DEPTH.
- starve_cnt:
  - Cleared to 0 on an aux grant or when fifo_count==0.
  - Otherwise (FIFO non-empty, pipe granted) increments; saturates at STARVE_LIMIT.
  - So stall_pipe is a single-cycle pulse followed by clear.
- pending_mask:
  - Bit issue_sel sets on issue_en when issue_sel!=0.
  - Bit clears at the edge an aux entry for that register is granted.
  - Set and clear of the same bit in one cycle: set wins.
  - Bit 0 is always 0.
- Protocol contract (not checked):
  - Decode never issues a second aux op to a register whose pending bit is set.
  - The pipe never writes a register whose pending bit is set.
- Reset asserted mid-operation: FIFO contents dropped, all state as at reset, next cycle rf_wen=0.

Test Plan:
- Reset then idle, all inputs 0 -> all outputs 0, aux_ready=1, no rf_wen pulse.
- pipe_wen=1, sel=5, wdat=0xDEADBEEF in cycle N -> rf_wen=1, rf_wsel=5, rf_wdat=0xDEADBEEF in N+1; pipe_sel=0 -> rf_wen stays 0.
- issue_en sel=9; aux_valid sel=9 wdat=0x12345678 with pipe idle -> pending_mask[9]=1 until the rf write of 0x12345678 to r9, then 0.
- Aux entry queued, pipe writes every cycle -> stall_pipe pulses after STARVE_LIMIT=4 pipe grants; that cycle aux is granted, starve_cnt clears, stall_pipe returns to 0.
- Two aux results with pipe busy -> fifo_count=2, aux_ready=0. A third aux_valid is held until a pop; results drain in FIFO order.
- Push and pop in the same cycle at count=1 -> count stays 1. nRST pulsed with count=2 -> count=0 and pending_mask=0 immediately, no stale writes afterwards.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// ============================================================================
// Module  : rf_write_arbiter_if
// Brief   : Register-file write-port bundle: pipe write-back, aux results,
//           aux issue tracking and the arbitrated write port.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface rf_write_arbiter_if #(
    parameter int FIFO_DEPTH = 2
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic          pipe_wen;
    logic [4:0]    pipe_sel;
    logic [31:0]   pipe_wdat;
    logic          aux_valid;
    logic [4:0]    aux_sel;
    logic [31:0]   aux_wdat;
    logic          aux_ready;
    logic          issue_en;
    logic [4:0]    issue_sel;
    logic          rf_wen;
    logic [4:0]    rf_wsel;
    logic [31:0]   rf_wdat;
    logic          stall_pipe;
    logic [31:0]   pending_mask;
    logic [CW-1:0] fifo_count;

    modport slave (
        input  pipe_wen, pipe_sel, pipe_wdat,
        input  aux_valid, aux_sel, aux_wdat,
        input  issue_en, issue_sel,
        output aux_ready, rf_wen, rf_wsel, rf_wdat,
        output stall_pipe, pending_mask, fifo_count
    );

    modport master (
        output pipe_wen, pipe_sel, pipe_wdat,
        output aux_valid, aux_sel, aux_wdat,
        output issue_en, issue_sel,
        input  aux_ready, rf_wen, rf_wsel, rf_wdat,
        input  stall_pipe, pending_mask, fifo_count
    );
endinterface

`default_nettype wire

// File: rtl/rf_write_arbiter.sv
// ============================================================================
// Module  : rf_write_arbiter
// Brief   : Shares the single RF write port between pipeline write-back and a
//           queued long-latency aux unit, with starvation stall and scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rf_write_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               CLK,
    input  logic               nRST,
    rf_write_arbiter_if.slave  bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] c_DEPTH        = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] c_STARVE_LIMIT = SW'(STARVE_LIMIT);

    logic [4:0]    r_fifo_sel [FIFO_DEPTH];
    logic [31:0]   r_fifo_dat [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic [31:0]   r_pending;
    logic          r_rf_wen;
    logic [4:0]    r_rf_wsel;
    logic [31:0]   r_rf_wdat;

    logic          w_stall;
    logic          w_ready;
    logic          w_push;
    logic          w_nonempty;
    logic          w_pipe_req;
    logic          w_grant_aux;
    logic          w_grant_pipe;
    logic [4:0]    w_head_sel;
    logic [31:0]   w_head_dat;
    logic [31:0]   w_pending_nxt;

    assign w_stall      = (r_starve == c_STARVE_LIMIT);
    assign w_ready      = (r_count < c_DEPTH);
    // Results for r0 complete the handshake but are never written.
    assign w_push       = bus.aux_valid && w_ready && (bus.aux_sel != 5'd0);
    assign w_nonempty   = (r_count != '0);
    assign w_pipe_req   = bus.pipe_wen && (bus.pipe_sel != 5'd0) && !w_stall;
    assign w_grant_aux  = w_nonempty && (w_stall || !w_pipe_req);
    assign w_grant_pipe = w_pipe_req;
    assign w_head_sel   = r_fifo_sel[r_rd_ptr];
    assign w_head_dat   = r_fifo_dat[r_rd_ptr];

    always_comb begin
        w_pending_nxt = r_pending;
        if (w_grant_aux) begin
            w_pending_nxt[w_head_sel] = 1'b0;
        end
        // Issue applied after the clear so a same-cycle set wins.
        if (bus.issue_en && (bus.issue_sel != 5'd0)) begin
            w_pending_nxt[bus.issue_sel] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo_sel[r_wr_ptr] <= bus.aux_sel;
            r_fifo_dat[r_wr_ptr] <= bus.aux_wdat;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_starve  <= '0;
            r_pending <= '0;
            r_rf_wen  <= 1'b0;
            r_rf_wsel <= '0;
            r_rf_wdat <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_grant_aux) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_grant_aux})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (w_grant_aux || !w_nonempty) begin
                r_starve <= '0;
            end else if (r_starve != c_STARVE_LIMIT) begin
                r_starve <= r_starve + SW'(1);
            end

            r_pending <= w_pending_nxt;

            if (w_grant_pipe) begin
                r_rf_wen  <= 1'b1;
                r_rf_wsel <= bus.pipe_sel;
                r_rf_wdat <= bus.pipe_wdat;
            end else if (w_grant_aux) begin
                r_rf_wen  <= 1'b1;
                r_rf_wsel <= w_head_sel;
                r_rf_wdat <= w_head_dat;
            end else begin
                r_rf_wen  <= 1'b0;
            end
        end
    end

    assign bus.aux_ready    = w_ready;
    assign bus.stall_pipe   = w_stall;
    assign bus.rf_wen       = r_rf_wen;
    assign bus.rf_wsel      = r_rf_wsel;
    assign bus.rf_wdat      = r_rf_wdat;
    assign bus.pending_mask = r_pending;
    assign bus.fifo_count   = r_count;
endmodule

`default_nettype wire
